framebuffer_writer: RTL and testbench

//  Consumer end of the sprite plot stream (plot / x_pix / y_pix / color): buffers plot

---
 rtl/framebuffer_writer_pkg.sv | 28 ++
 rtl/framebuffer_writer_fifo.sv | 52 +++++
 rtl/framebuffer_writer.sv | 151 +++++++++++++++
 tb/tb_framebuffer_writer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/framebuffer_writer_pkg.sv
// rtl/framebuffer_writer_pkg.sv - shared constants, state encoding and FIFO entry type
// Purpose: default screen geometry, frame RAM address width, colour width,
//          clear colour, the writer FSM state encoding and the packed plot entry
//          that is stored in the plot FIFO.
// Ports:   none (package)
package framebuffer_writer_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_ADDR_W   = 15;
  localparam int DEF_FIFO_AW  = 3;
  localparam int PIX_W        = 10;
  localparam int COLOR_W      = 3;

  localparam logic [COLOR_W-1:0] DEF_CLEAR_COLOR = 3'b000;

  typedef enum logic {
    S_DRAIN = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  typedef struct packed {
    logic [PIX_W-1:0]   x;
    logic [PIX_W-1:0]   y;
    logic [COLOR_W-1:0] color;
  } plot_entry_t;

endpackage

// File: rtl/framebuffer_writer_fifo.sv
// rtl/framebuffer_writer_fifo.sv - synchronous FIFO holding pending plot requests
// Purpose: plot_fifo, a single-clock FIFO of depth 2**AW with a show-ahead head.
// Ports:   clk, reset_n (async active-low), push_i/wdata_i write side,
//          pop_i read side, head_o current head entry, full_o, empty_o status.
module plot_fifo #(
  parameter int WIDTH = 23,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A push against a full FIFO is refused even if a pop happens the same cycle;
  // the producer sees !full as its ready, so this keeps both views consistent.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - plot stream consumer: FIFO, clip, address calc, clear sequencer
// Purpose: buffers plot requests, drops off-screen pixels, converts (x,y) to a
//          linear frame RAM address and issues registered single-cycle writes when
//          granted; also sweeps the whole screen with CLEAR_COLOR on request.
// Ports:   clk, reset_n (async active-low)
//          plot, x_pix, y_pix, color, in_ready    - plot request stream
//          clear_req, clear_busy                  - full-screen clear control
//          mem_grant, mem_we, mem_addr, mem_data  - frame RAM write port
//          overflow                               - sticky dropped-request flag
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int                 SCREEN_W    = DEF_SCREEN_W,
  parameter int                 SCREEN_H    = DEF_SCREEN_H,
  parameter int                 ADDR_W      = DEF_ADDR_W,
  parameter int                 FIFO_AW     = DEF_FIFO_AW,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = DEF_CLEAR_COLOR
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               plot,
  input  logic [PIX_W-1:0]   x_pix,
  input  logic [PIX_W-1:0]   y_pix,
  input  logic [COLOR_W-1:0] color,
  output logic               in_ready,
  input  logic               clear_req,
  output logic               clear_busy,
  input  logic               mem_grant,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               overflow
);

  localparam logic [PIX_W-1:0]  X_LIM     = PIX_W'(SCREEN_W);
  localparam logic [PIX_W-1:0]  Y_LIM     = PIX_W'(SCREEN_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  state_e             state_q, state_d;
  logic               pending_q, pending_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               overflow_q;

  plot_entry_t        wr_entry, head;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic               in_range;
  logic [ADDR_W-1:0]  lin_addr;

  assign in_ready  = !fifo_full;
  assign fifo_push = plot && in_ready;
  assign wr_entry  = '{x: x_pix, y: y_pix, color: color};

  plot_fifo #(
    .WIDTH ($bits(plot_entry_t)),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .wdata_i (wr_entry),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Range check on the raw 10-bit coordinates so large values can never alias
  // back on-screen through the multiply.
  assign in_range = (head.x < X_LIM) && (head.y < Y_LIM);
  assign lin_addr = ADDR_W'(head.y) * ADDR_W'(SCREEN_W) + ADDR_W'(head.x);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    fifo_pop  = 1'b0;

    // A clear request only registers while draining; mid-clear it is ignored.
    if (clear_req && (state_q == S_DRAIN)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_DRAIN: begin
        if (!fifo_empty) begin
          if (mem_grant) begin
            fifo_pop = 1'b1;
            if (in_range) begin
              we_d   = 1'b1;
              addr_d = lin_addr;
              data_d = head.color;
            end
          end
        end else if (pending_q) begin
          // Only start once everything plotted before the request has landed.
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (mem_grant) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          data_d = CLEAR_COLOR;
          if (cnt_q == LAST_ADDR) begin
            cnt_d     = '0;
            pending_d = 1'b0;
            state_d   = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_DRAIN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_DRAIN;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      if (plot && !in_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign clear_busy = pending_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb/tb_framebuffer_writer.sv - directed self-checking bench for framebuffer_writer
module tb_framebuffer_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        plot;
  logic [9:0]  x_pix, y_pix;
  logic [2:0]  color;
  logic        in_ready;
  logic        clear_req;
  logic        clear_busy;
  logic        mem_grant;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        overflow;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [14:0] addr;
    logic [2:0]  data;
    logic        busy;
  } wr_t;

  wr_t wq[$];
  wr_t mon_w;

  framebuffer_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .plot       (plot),
    .x_pix      (x_pix),
    .y_pix      (y_pix),
    .color      (color),
    .in_ready   (in_ready),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .mem_grant  (mem_grant),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      mon_w.addr = mem_addr;
      mon_w.data = mem_data;
      mon_w.busy = clear_busy;
      wq.push_back(mon_w);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset_n   = 1'b0;
    plot      = 1'b0;
    x_pix     = '0;
    y_pix     = '0;
    color     = '0;
    clear_req = 1'b0;
    mem_grant = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    wq.delete();
  endtask

  task automatic send_plot(input int x, input int y, input int c);
    plot  = 1'b1;
    x_pix = 10'(x);
    y_pix = 10'(y);
    color = 3'(c);
    @(negedge clk);
    plot = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
  endtask

  task automatic wait_clear_done(input string name);
    for (int k = 0; k < 25000 && clear_busy; k++) @(negedge clk);
    n_cmp++;
    if (clear_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_timeout: clear_busy=%b required 0", name, clear_busy);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
    n_cmp++; if (mem_addr !== 15'd0) begin n_bad++; $display("FAIL rst_mem_addr: got %0d required 0", mem_addr); end
    n_cmp++; if (mem_data !== 3'd0) begin n_bad++; $display("FAIL rst_mem_data: got %0d required 0", mem_data); end
    n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL rst_clear_busy: got %b required 0", clear_busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b required 0", overflow); end
  endtask

  task automatic test_single();
    apply_reset();
    mem_grant = 1'b1;
    send_plot(3, 2, 5);
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL single_early: mem_we=%b required 0", mem_we); end
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL single_we: mem_we=%b required 1", mem_we); end
    n_cmp++; if (mem_addr !== 15'd323) begin n_bad++; $display("FAIL single_addr: got %0d required 323", mem_addr); end
    n_cmp++; if (mem_data !== 3'd5) begin n_bad++; $display("FAIL single_data: got %0d required 5", mem_data); end
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL single_pulse: mem_we=%b required 0", mem_we); end
    repeat (3) @(negedge clk);
    n_cmp++; if (wq.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d writes required 1", wq.size()); end
  endtask

  task automatic test_overflow();
    int bad;
    apply_reset();
    mem_grant = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 7) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_ready7: in_ready=%b required 1", in_ready); end
      end
      if (i == 8) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_full: in_ready=%b required 0", in_ready); end
      end
      plot  = 1'b1;
      x_pix = 10'(10 + i);
      y_pix = 10'(i);
      color = 3'(i);
      @(negedge clk);
    end
    plot = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    n_cmp++; if (wq.size() !== 0) begin n_bad++; $display("FAIL ovf_nogrant: got %0d writes required 0", wq.size()); end
    mem_grant = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++; if (wq.size() !== 8) begin n_bad++; $display("FAIL ovf_count: got %0d writes required 8", wq.size()); end
    if (wq.size() == 8) begin
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        if (wq[i].addr !== 15'(i * 160 + 10 + i) || wq[i].data !== 3'(i)) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ovf_order: %0d wrong entries required 0", bad); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_drained: in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_clip();
    apply_reset();
    mem_grant = 1'b1;
    send_plot(160, 0, 1);
    send_plot(0, 120, 2);
    send_plot(159, 119, 6);
    repeat (5) @(negedge clk);
    n_cmp++; if (wq.size() !== 1) begin n_bad++; $display("FAIL clip_count: got %0d writes required 1", wq.size()); end
    if (wq.size() == 1) begin
      n_cmp++; if (wq[0].addr !== 15'd19199) begin n_bad++; $display("FAIL clip_addr: got %0d required 19199", wq[0].addr); end
      n_cmp++; if (wq[0].data !== 3'd6) begin n_bad++; $display("FAIL clip_data: got %0d required 6", wq[0].data); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clip_overflow: got %b required 0", overflow); end
  endtask

  task automatic test_clear();
    int bad;
    apply_reset();
    mem_grant = 1'b0;
    send_plot(1, 0, 1);
    send_plot(2, 0, 2);
    send_plot(0, 1, 3);
    pulse_clear();
    n_cmp++; if (clear_busy !== 1'b1) begin n_bad++; $display("FAIL clear_busy_set: got %b required 1", clear_busy); end
    pulse_clear();
    mem_grant = 1'b1;
    wait_clear_done("clear");
    repeat (4) @(negedge clk);
    n_cmp++; if (wq.size() !== 19203) begin n_bad++; $display("FAIL clear_count: got %0d writes required 19203", wq.size()); end
    if (wq.size() == 19203) begin
      bad = 0;
      if (wq[0].addr !== 15'd1   || wq[0].data !== 3'd1) bad++;
      if (wq[1].addr !== 15'd2   || wq[1].data !== 3'd2) bad++;
      if (wq[2].addr !== 15'd160 || wq[2].data !== 3'd3) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clear_plots_first: %0d wrong entries required 0", bad); end
      bad = 0;
      for (int j = 0; j < 19200; j++) begin
        if (wq[3 + j].addr !== 15'(j) || wq[3 + j].data !== 3'd0) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clear_sweep: %0d wrong entries required 0", bad); end
      n_cmp++; if (wq[19201].busy !== 1'b1) begin n_bad++; $display("FAIL clear_busy_held: got %b required 1", wq[19201].busy); end
      n_cmp++; if (wq[19202].busy !== 1'b0) begin n_bad++; $display("FAIL clear_busy_last: got %b required 0", wq[19202].busy); end
    end
  endtask

  task automatic test_plot_during_clear();
    apply_reset();
    mem_grant = 1'b1;
    pulse_clear();
    repeat (50) @(negedge clk);
    send_plot(5, 5, 7);
    repeat (20) @(negedge clk);
    pulse_clear();
    wait_clear_done("dclear");
    repeat (5) @(negedge clk);
    n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL dclear_retrigger: clear_busy=%b required 0", clear_busy); end
    repeat (5) @(negedge clk);
    n_cmp++; if (wq.size() !== 19201) begin n_bad++; $display("FAIL dclear_count: got %0d writes required 19201", wq.size()); end
    if (wq.size() == 19201) begin
      n_cmp++; if (wq[19199].addr !== 15'd19199) begin n_bad++; $display("FAIL dclear_last_clear: got %0d required 19199", wq[19199].addr); end
      n_cmp++; if (wq[19200].addr !== 15'd805 || wq[19200].data !== 3'd7) begin
        n_bad++; $display("FAIL dclear_plot: got addr %0d data %0d required 805/7", wq[19200].addr, wq[19200].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    mem_grant = 1'b1;
    pulse_clear();
    repeat (30) @(negedge clk);
    send_plot(9, 9, 1);
    send_plot(10, 10, 2);
    repeat (5) @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_we: got %b required 1", mem_we); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rmid_we_drop: got %b required 0", mem_we); end
    n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b required 0", clear_busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b required 1", in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    wq.delete();
    repeat (30) @(negedge clk);
    n_cmp++; if (wq.size() !== 0) begin n_bad++; $display("FAIL rmid_no_writes: got %0d writes required 0", wq.size()); end
    n_cmp++; if (clear_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy_after: got %b required 0", clear_busy); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_overflow();
    test_clip();
    test_clear();
    test_plot_during_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
